qsn_inverse_shifter: RTL

QSN_INVERSE_SHIFTER -- requirements
Module: qsn_inverse_shifter

---
 rtl/qsn_inverse_shifter_pkg.sv | 20 ++
 rtl/qsn_inverse_shifter_if.sv | 27 ++
 rtl/qsn_shift_fifo.sv | 104 ++++++++++
 rtl/qsn_inverse_shifter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/qsn_inverse_shifter_pkg.sv
// qsn_pkg: shared constants and types for the QSN inverse shifter.
//   PERMUTATION_LENGTH : default circulant size Z
//   SHIFT_W            : width of a shift factor
//   QUAN_SIZE          : default number of message bit-planes
//   ROT_STAGES         : number of conditional power-of-two rotate steps
//   pop_src_e          : where a popped shift factor comes from
package qsn_pkg;

    localparam int unsigned PERMUTATION_LENGTH = 765;
    localparam int unsigned SHIFT_W            = 10;
    localparam int unsigned QUAN_SIZE          = 3;
    localparam int unsigned ROT_STAGES         = $clog2(PERMUTATION_LENGTH);

    typedef enum logic [1:0] {
        POP_STORED,
        POP_BYPASS,
        POP_UNDERFLOW
    } pop_src_e;

endpackage

// File: rtl/qsn_inverse_shifter_if.sv
// qsn_inverse_shifter_if: message word path of the inverse shifter.
//   in_valid, sw_in_bit0..2   : returning word (master -> slave)
//   out_valid, sw_out_bit0..2 : de-permuted word (slave -> master)
interface qsn_inverse_shifter_if #(
    parameter int unsigned Z = qsn_pkg::PERMUTATION_LENGTH
);

    logic         in_valid;
    logic [Z-1:0] sw_in_bit0;
    logic [Z-1:0] sw_in_bit1;
    logic [Z-1:0] sw_in_bit2;
    logic         out_valid;
    logic [Z-1:0] sw_out_bit0;
    logic [Z-1:0] sw_out_bit1;
    logic [Z-1:0] sw_out_bit2;

    modport master (
        output in_valid, sw_in_bit0, sw_in_bit1, sw_in_bit2,
        input  out_valid, sw_out_bit0, sw_out_bit1, sw_out_bit2
    );

    modport slave (
        input  in_valid, sw_in_bit0, sw_in_bit1, sw_in_bit2,
        output out_valid, sw_out_bit0, sw_out_bit1, sw_out_bit2
    );

endinterface

// File: rtl/qsn_shift_fifo.sv
// qsn_shift_fifo: stores the shift factors applied by the forward permutation
// until the matching message word returns.
//   sys_clk, rstn  : clock, asynchronous active-low reset
//   push           : store push_factor (factors >= Z are stored as 0)
//   push_factor    : factor to store
//   pop            : consume one factor this cycle
//   pop_factor     : factor consumed by pop (combinational)
//   fifo_full/empty: occupancy status
//   err_*          : sticky overflow / underflow / out-of-range flags
module qsn_shift_fifo #(
    parameter int unsigned PERMUTATION_LENGTH = qsn_pkg::PERMUTATION_LENGTH,
    parameter int unsigned DEPTH              = 8
) (
    input  logic                        sys_clk,
    input  logic                        rstn,
    input  logic                        push,
    input  logic [qsn_pkg::SHIFT_W-1:0] push_factor,
    input  logic                        pop,
    output logic [qsn_pkg::SHIFT_W-1:0] pop_factor,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic                        err_overflow,
    output logic                        err_underflow,
    output logic                        err_range
);

    import qsn_pkg::*;

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [SHIFT_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               range_bad;
    logic [SHIFT_W-1:0] push_clean;
    pop_src_e           pop_src;
    logic               wr_en;
    logic               rd_en;

    always_comb begin
        range_bad  = (32'(push_factor) >= PERMUTATION_LENGTH);
        push_clean = range_bad ? '0 : push_factor;
        fifo_empty = (count == '0);
        fifo_full  = (count == CW'(DEPTH));

        if (!fifo_empty) begin
            pop_src = POP_STORED;
        end else if (push) begin
            pop_src = POP_BYPASS;
        end else begin
            pop_src = POP_UNDERFLOW;
        end

        pop_factor = '0;
        unique case (pop_src)
            POP_STORED:    pop_factor = mem[rd_ptr];
            POP_BYPASS:    pop_factor = push_clean;
            POP_UNDERFLOW: pop_factor = '0;
            default:       pop_factor = '0;
        endcase

        rd_en = pop && !fifo_empty;
        // A pop on an empty FIFO consumes the same-cycle push directly, so
        // that push is not stored. When full, a push only fits alongside a pop.
        wr_en = push && !(pop && fifo_empty) && (!fifo_full || pop);
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_clean;
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_range     <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(wr_en) - CW'(rd_en);
            if (push && fifo_full && !pop) begin
                err_overflow <= 1'b1;
            end
            if (pop && fifo_empty && !push) begin
                err_underflow <= 1'b1;
            end
            if (push && range_bad) begin
                err_range <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/qsn_inverse_shifter.sv
// qsn_inverse_shifter: undoes the forward QSN cyclic permutation on every
// bit-plane of a returning message word: sw_out[i] = sw_in[(i - s) mod Z],
// where s is the factor popped from the factor FIFO for that word.
//   sys_clk, rstn     : clock, asynchronous active-low reset
//   fwd_shift_valid   : push fwd_shift_factor into the factor FIFO
//   fwd_shift_factor  : factor used by the forward permutation
//   sw_bus            : in_valid/sw_in_bit0..2 in, out_valid/sw_out_bit0..2 out
//   fifo_full/empty   : factor FIFO status
//   err_overflow/underflow/range : sticky error flags, cleared only by reset
module qsn_inverse_shifter #(
    parameter int unsigned PERMUTATION_LENGTH = qsn_pkg::PERMUTATION_LENGTH,
    parameter int unsigned PIPELINE_STAGES    = 4,
    parameter int unsigned QUAN_SIZE          = qsn_pkg::QUAN_SIZE,
    parameter int unsigned FACTOR_FIFO_DEPTH  = 8
) (
    input  logic                        sys_clk,
    input  logic                        rstn,
    input  logic                        fwd_shift_valid,
    input  logic [qsn_pkg::SHIFT_W-1:0] fwd_shift_factor,
    qsn_inverse_shifter_if.slave        sw_bus,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic                        err_overflow,
    output logic                        err_underflow,
    output logic                        err_range
);

    import qsn_pkg::*;

    localparam int unsigned Z     = PERMUTATION_LENGTH;
    localparam int unsigned NP    = PIPELINE_STAGES;
    localparam int unsigned ROT_N = $clog2(Z);

    typedef logic [QUAN_SIZE-1:0][Z-1:0] word_t;

    // Rotate towards higher indices by k: r[i] = v[(i - k) mod Z], k < Z.
    function automatic logic [Z-1:0] rotate_plane(input logic [Z-1:0] v,
                                                  input int unsigned k);
        logic [Z-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < Z; i++) begin
            r[i] = v[(i + Z - k) % Z];
        end
        return r;
    endfunction

    // Rotate step j (by 2^j mod Z) is handled in register stage j*NP/ROT_N,
    // spreading the ROT_N steps evenly over the pipeline. Because s < Z, the
    // sum of the selected steps equals s and the composition is exact mod Z.
    function automatic word_t rotate_stage(input word_t w,
                                           input logic [SHIFT_W-1:0] s,
                                           input int unsigned p);
        word_t r;
        r = w;
        for (int unsigned j = 0; j < ROT_N; j++) begin
            if (((j * NP) / ROT_N) == p && s[j]) begin
                for (int unsigned q = 0; q < QUAN_SIZE; q++) begin
                    r[q] = rotate_plane(r[q], (32'd1 << j) % Z);
                end
            end
        end
        return r;
    endfunction

    logic [SHIFT_W-1:0] pop_factor;
    word_t              in_word;
    word_t              src_data [NP];
    logic [SHIFT_W-1:0] src_s    [NP];
    logic               src_vld  [NP];
    word_t              nxt_data [NP];
    word_t              stg_data [NP];
    logic [SHIFT_W-1:0] stg_s    [NP];
    logic               stg_vld  [NP];

    qsn_shift_fifo #(
        .PERMUTATION_LENGTH (Z),
        .DEPTH              (FACTOR_FIFO_DEPTH)
    ) u_shift_fifo (
        .sys_clk       (sys_clk),
        .rstn          (rstn),
        .push          (fwd_shift_valid),
        .push_factor   (fwd_shift_factor),
        .pop           (sw_bus.in_valid),
        .pop_factor    (pop_factor),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_range     (err_range)
    );

    always_comb begin
        in_word    = '0;
        in_word[0] = sw_bus.sw_in_bit0;
        in_word[1] = sw_bus.sw_in_bit1;
        in_word[2] = sw_bus.sw_in_bit2;

        src_data[0] = in_word;
        src_s[0]    = pop_factor;
        src_vld[0]  = sw_bus.in_valid;
        for (int unsigned p = 1; p < NP; p++) begin
            src_data[p] = stg_data[p-1];
            src_s[p]    = stg_s[p-1];
            src_vld[p]  = stg_vld[p-1];
        end

        for (int unsigned p = 0; p < NP; p++) begin
            nxt_data[p] = rotate_stage(src_data[p], src_s[p], p);
        end
    end

    // Stages load only on a valid word, so the last stage holds its value
    // while out_valid is low.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned p = 0; p < NP; p++) begin
                stg_vld[p]  <= 1'b0;
                stg_s[p]    <= '0;
                stg_data[p] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NP; p++) begin
                stg_vld[p] <= src_vld[p];
                if (src_vld[p]) begin
                    stg_data[p] <= nxt_data[p];
                    stg_s[p]    <= src_s[p];
                end
            end
        end
    end

    assign sw_bus.out_valid   = stg_vld[NP-1];
    assign sw_bus.sw_out_bit0 = stg_data[NP-1][0];
    assign sw_bus.sw_out_bit1 = stg_data[NP-1][1];
    assign sw_bus.sw_out_bit2 = stg_data[NP-1][2];

endmodule
